// File: rtl/lcd_text_writer.sv
// Streams up to four lines of text to an HD44780 nibble transmitter as address + data bytes, high nibble first.
// Defining LCD_TEXT_CLEAR_EN prefixes every frame with a Clear Display instruction.
module lcd_text_writer #(
    parameter int LINE_LENGTH = 16,
    parameter int NUM_LINES   = 2
) (
    input  logic                                CLK,
    input  logic                                RESET,
    input  logic                                sendText,
    input  logic [8*LINE_LENGTH*NUM_LINES-1:0]  text,
    input  logic [NUM_LINES-1:0]                lineMask,
    output logic                                busy,
    output logic                                sendingDone,
    input  logic                                commandDone,
    output logic [3:0]                          commandToSend,
    output logic                                sendCommand,
    output logic                                read_busy,
    output logic                                commandToSendRs
);

    localparam int TOTAL = LINE_LENGTH * NUM_LINES;
    localparam int CW    = $clog2(LINE_LENGTH + 1);
`ifdef LCD_TEXT_CLEAR_EN
    localparam logic CLEAR_EN = 1'b1;
`else
    localparam logic CLEAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, NEXT} state_t;

    state_t                 state_q, state_d;
    logic [8*TOTAL-1:0]     text_q, text_d;
    logic [3:0]             mask_q, mask_d;
    logic [1:0]             line_q, line_d;
    logic [CW-1:0]          char_q, char_d;
    logic                   clr_q, clr_d;
    logic [7:0]             byte_q, byte_d;
    logic                   rs_q, rs_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   send_q, send_d;
    logic [3:0]             cmd_q, cmd_d;
    logic                   rb_q, rb_d;
    logic                   rso_q, rso_d;

    logic [3:0]             mask_in;
    logic [1:0]             first_line;
    logic [1:0]             next_line;
    logic                   next_found;
    logic [6:0]             addr;
    logic [7:0]             char_byte;
    int                     cidx;

    always_comb begin
        mask_in    = 4'(lineMask);
        first_line = 2'd0;
        for (int l = 3; l >= 0; l--) begin
            if (mask_in[l]) first_line = 2'(l);
        end

        // Next masked line strictly above the current one, so skipped lines cost no cycles.
        next_line  = line_q;
        next_found = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (k > int'(line_q) && mask_q[k]) begin
                next_line  = 2'(k);
                next_found = 1'b1;
            end
        end

        case (line_q)
            2'd0:    addr = 7'h00;
            2'd1:    addr = 7'h40;
            2'd2:    addr = 7'(LINE_LENGTH);
            default: addr = 7'(64 + LINE_LENGTH);
        endcase

        cidx      = (char_q == '0) ? 0 : int'(char_q) - 1;
        char_byte = text_q[8*(TOTAL-1-(int'(line_q)*LINE_LENGTH + cidx)) +: 8];
    end

    always_comb begin
        state_d = state_q;
        text_d  = text_q;
        mask_d  = mask_q;
        line_d  = line_q;
        char_d  = char_q;
        clr_d   = clr_q;
        byte_d  = byte_q;
        rs_d    = rs_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        send_d  = 1'b0;
        cmd_d   = cmd_q;
        rb_d    = rb_q;
        rso_d   = rso_q;

        case (state_q)
            IDLE: begin
                // busy is still high in the cycle sendingDone is shown, which blocks a request here.
                if (sendText && !busy_q) begin
                    text_d  = text;
                    mask_d  = mask_in;
                    line_d  = first_line;
                    char_d  = '0;
                    clr_d   = CLEAR_EN;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end else begin
                    busy_d = 1'b0;
                end
            end
            LOAD: begin
                if (clr_q) begin
                    byte_d  = 8'h01;
                    rs_d    = 1'b0;
                    state_d = SEND_HI;
                end else if (!mask_q[line_q]) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (char_q == '0) begin
                        byte_d = {1'b1, addr};
                        rs_d   = 1'b0;
                    end else begin
                        byte_d = char_byte;
                        rs_d   = 1'b1;
                    end
                    state_d = SEND_HI;
                end
            end
            SEND_HI: begin
                send_d  = 1'b1;
                cmd_d   = byte_q[7:4];
                rb_d    = 1'b0;
                rso_d   = rs_q;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (commandDone) state_d = SEND_LO;
            end
            SEND_LO: begin
                send_d  = 1'b1;
                cmd_d   = byte_q[3:0];
                rb_d    = 1'b1;
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (commandDone) state_d = NEXT;
            end
            NEXT: begin
                if (clr_q) begin
                    clr_d = 1'b0;
                    if (mask_q[line_q]) begin
                        state_d = LOAD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (char_q != CW'(LINE_LENGTH)) begin
                    char_d  = char_q + CW'(1);
                    state_d = LOAD;
                end else if (next_found) begin
                    line_d  = next_line;
                    char_d  = '0;
                    state_d = LOAD;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            text_q  <= '0;
            mask_q  <= '0;
            line_q  <= '0;
            char_q  <= '0;
            clr_q   <= 1'b0;
            byte_q  <= '0;
            rs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            send_q  <= 1'b0;
            cmd_q   <= '0;
            rb_q    <= 1'b0;
            rso_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            text_q  <= text_d;
            mask_q  <= mask_d;
            line_q  <= line_d;
            char_q  <= char_d;
            clr_q   <= clr_d;
            byte_q  <= byte_d;
            rs_q    <= rs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            send_q  <= send_d;
            cmd_q   <= cmd_d;
            rb_q    <= rb_d;
            rso_q   <= rso_d;
        end
    end

    assign busy            = busy_q;
    assign sendingDone     = done_q;
    assign sendCommand     = send_q;
    assign commandToSend   = cmd_q;
    assign read_busy       = rb_q;
    assign commandToSendRs = rso_q;

endmodule

// File: tb/tb_lcd_text_writer.sv
// Bench for lcd_text_writer: default 16x2 instance plus a 20x4 instance, with a nibble-stream scoreboard.
module tb_lcd_text_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         st1 = 1'b0, cd1 = 1'b0;
    logic [255:0] txt1 = '0;
    logic [1:0]   m1 = '0;
    logic         busy1, sd1, sc1, rb1, rs1;
    logic [3:0]   cmd1;

    logic         st2 = 1'b0, cd2 = 1'b0;
    logic [639:0] txt2 = '0;
    logic [3:0]   m2 = '0;
    logic         busy2, sd2, sc2, rb2, rs2;
    logic [3:0]   cmd2;

    lcd_text_writer dut1 (
        .CLK(clk), .RESET(rst), .sendText(st1), .text(txt1), .lineMask(m1),
        .busy(busy1), .sendingDone(sd1), .commandDone(cd1), .commandToSend(cmd1),
        .sendCommand(sc1), .read_busy(rb1), .commandToSendRs(rs1)
    );

    lcd_text_writer #(.LINE_LENGTH(20), .NUM_LINES(4)) dut2 (
        .CLK(clk), .RESET(rst), .sendText(st2), .text(txt2), .lineMask(m2),
        .busy(busy2), .sendingDone(sd2), .commandDone(cd2), .commandToSend(cmd2),
        .sendCommand(sc2), .read_busy(rb2), .commandToSendRs(rs2)
    );

    typedef struct packed {
        logic [3:0] nib;
        logic       rs;
        logic       rb;
    } exp_t;

    typedef struct {
        logic [1:0]   mask;
        logic [255:0] txt;
        logic [7:0]   first;
        int           pulses;
        logic         ack_same;
    } vec_t;

    exp_t       q1[$], q2[$];
    logic [3:0] obs1[$], obs2[$];
    int         n_vec = 0, n_err = 0;
    int         p1 = 0, p2 = 0, d1 = 0, d2 = 0;
    logic       pend1 = 1'b0, pend2 = 1'b0, ack_same = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_byte(input int d, input logic [7:0] b, input logic rs);
        exp_t hi, lo;
        hi = '{nib: b[7:4], rs: rs, rb: 1'b0};
        lo = '{nib: b[3:0], rs: rs, rb: 1'b1};
        if (d == 1) begin q1.push_back(hi); q1.push_back(lo); end
        else        begin q2.push_back(hi); q2.push_back(lo); end
    endtask

    // Expected frame: per masked line, 0x80|address (RS=0) then the line's characters (RS=1).
    task automatic push_model(input int d, input logic [639:0] txt, input int len, input int nl,
                              input logic [3:0] m);
        int adr;
        for (int l = 0; l < nl; l++) begin
            if (m[l]) begin
                adr = (l == 0) ? 0 : (l == 1) ? 64 : (l == 2) ? len : 64 + len;
                push_byte(d, 8'h80 | 8'(adr % 128), 1'b0);
                for (int c = 0; c < len; c++)
                    push_byte(d, txt[8*(len*nl-1-(l*len+c)) +: 8], 1'b1);
            end
        end
    endtask

    task automatic score(input int d, input logic [3:0] nib, input logic rs, input logic rb);
        exp_t e;
        if ((d == 1 && q1.size() == 0) || (d == 2 && q2.size() == 0)) begin
            chk(d == 1 ? "unexpected_pulse1" : "unexpected_pulse2", {26'b0, nib, rs, rb}, 32'hFFFF_FFFF);
        end else begin
            e = (d == 1) ? q1.pop_front() : q2.pop_front();
            chk(d == 1 ? "nibble1" : "nibble2", {26'b0, nib, rs, rb}, {26'b0, e.nib, e.rs, e.rb});
        end
    endtask

    // One cycle: transmitter model acks, then outputs are sampled mid-cycle.
    task automatic tick();
        @(negedge clk);
        if (ack_same) begin
            cd1   = sc1;
            pend1 = 1'b0;
        end else begin
            cd1   = pend1;
            pend1 = sc1;
        end
        cd2   = pend2;
        pend2 = sc2;
        if (sc1) begin p1++; obs1.push_back(cmd1); score(1, cmd1, rs1, rb1); end
        if (sc2) begin p2++; obs2.push_back(cmd2); score(2, cmd2, rs2, rb2); end
        if (sd1) d1++;
        if (sd2) d2++;
    endtask

    task automatic wait_done1(input int d0);
        for (int i = 0; i < 3000; i++) begin
            if (d1 != d0) break;
            tick();
        end
    endtask

    task automatic run_frame1(input vec_t v);
        int p0, d0;
        p0 = p1;
        d0 = d1;
        ack_same = v.ack_same;
        obs1.delete();
        m1   = v.mask;
        txt1 = v.txt;
        push_model(1, {384'b0, v.txt}, 16, 2, {2'b00, v.mask});
        st1 = 1'b1;
        tick();
        st1 = 1'b0;
        txt1 = ~v.txt;
        m1   = ~v.mask;
        wait_done1(d0);
        repeat (3) tick();
        chk("pulses", p1 - p0, v.pulses);
        chk("done_count", d1 - d0, 1);
        chk("busy_after", {31'b0, busy1}, 0);
        chk("queue_left", q1.size(), 0);
        if (v.pulses > 0)
            chk("first_byte", (obs1.size() >= 2) ? {24'b0, obs1[0], obs1[1]} : 32'hFFFF_FFFF, {24'b0, v.first});
        ack_same = 1'b0;
    endtask

    localparam logic [255:0] TA = {"HELLO WORLD     ", "0123456789ABCDEF"};
    localparam logic [255:0] TB = {"abcdefghijklmnop", "Line two text!!!"};

    vec_t tbl[5];
    int   p0, d0;

    initial begin
        tbl[0] = '{mask: 2'b11, txt: TA, first: 8'h80, pulses: 68, ack_same: 1'b0};
        tbl[1] = '{mask: 2'b10, txt: TA, first: 8'hC0, pulses: 34, ack_same: 1'b0};
        tbl[2] = '{mask: 2'b01, txt: TB, first: 8'h80, pulses: 34, ack_same: 1'b1};
        tbl[3] = '{mask: 2'b00, txt: TA, first: 8'h00, pulses: 0,  ack_same: 1'b0};
        tbl[4] = '{mask: 2'b11, txt: TB, first: 8'h80, pulses: 68, ack_same: 1'b1};

        repeat (3) tick();
        chk("reset_out1", {24'b0, busy1, sd1, sc1, cmd1, rb1, rs1}, 0);
        chk("reset_out2", {24'b0, busy2, sd2, sc2, cmd2, rb2, rs2}, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_frame1(tbl[i]);

        // Empty mask: busy from N+1, sendingDone at N+2, idle at N+3.
        d0 = d1;
        m1 = 2'b00;
        st1 = 1'b1;
        tick();
        st1 = 1'b0;
        chk("mask0_n1", {30'b0, busy1, sd1}, 32'h2);
        tick();
        chk("mask0_n2", {30'b0, busy1, sd1}, 32'h3);
        tick();
        chk("mask0_n3", {30'b0, busy1, sd1}, 32'h0);
        chk("mask0_done", d1 - d0, 1);

        // First-nibble and low-nibble latency.
        d0 = d1;
        m1 = 2'b01;
        txt1 = TA;
        push_model(1, {384'b0, TA}, 16, 2, 4'b0001);
        st1 = 1'b1;
        tick();
        st1 = 1'b0;
        chk("lat_n1", {31'b0, sc1}, 0);
        tick();
        chk("lat_n2", {31'b0, sc1}, 0);
        tick();
        chk("lat_hi", {25'b0, sc1, cmd1, rb1, rs1}, {25'b0, 1'b1, 4'h8, 1'b0, 1'b0});
        tick();
        tick();
        chk("lat_n5", {31'b0, sc1}, 0);
        tick();
        chk("lat_lo", {25'b0, sc1, cmd1, rb1, rs1}, {25'b0, 1'b1, 4'h0, 1'b1, 1'b0});
        wait_done1(d0);
        chk("lat_done", d1 - d0, 1);
        repeat (3) tick();

        // Input churn and repeated requests while busy; sendText still high in the done cycle.
        p0 = p1;
        d0 = d1;
        m1 = 2'b11;
        txt1 = TA;
        push_model(1, {384'b0, TA}, 16, 2, 4'b0011);
        st1 = 1'b1;
        tick();
        st1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            st1  = (i % 2 == 1);
            txt1 = {8{$urandom}};
            m1   = 2'($urandom);
            tick();
        end
        st1 = 1'b1;
        wait_done1(d0);
        tick();
        st1 = 1'b0;
        repeat (30) tick();
        chk("churn_pulses", p1 - p0, 68);
        chk("churn_done", d1 - d0, 1);
        chk("churn_busy", {31'b0, busy1}, 0);
        chk("churn_queue", q1.size(), 0);

        // Reset while waiting for the low nibble to complete.
        d0 = d1;
        m1 = 2'b11;
        txt1 = TB;
        push_model(1, {384'b0, TB}, 16, 2, 4'b0011);
        st1 = 1'b1;
        tick();
        st1 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sc1 && rb1) break;
            tick();
        end
        chk("rst_reached_lo", {31'b0, sc1 && rb1}, 1);
        rst = 1'b1;
        tick();
        chk("rst_outputs", {24'b0, busy1, sd1, sc1, cmd1, rb1, rs1}, 0);
        q1.delete();
        rst = 1'b0;
        repeat (10) tick();
        chk("rst_no_done", d1 - d0, 0);
        chk("rst_idle", {30'b0, busy1, sc1}, 0);
        run_frame1(tbl[0]);

        // 20x4 instance, lines 2 and 3 only.
        for (int i = 0; i < 80; i++) txt2[8*(79-i) +: 8] = 8'(8'h21 + i);
        m2 = 4'b1100;
        push_model(2, txt2, 20, 4, 4'b1100);
        obs2.delete();
        st2 = 1'b1;
        tick();
        st2 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (d2 != 0) break;
            tick();
        end
        repeat (3) tick();
        chk("w20_pulses", p2, 84);
        chk("w20_done", d2, 1);
        chk("w20_busy", {31'b0, busy2}, 0);
        chk("w20_queue", q2.size(), 0);
        chk("w20_addr2", (obs2.size() >= 2) ? {24'b0, obs2[0], obs2[1]} : 32'hFFFF_FFFF, 32'h94);
        chk("w20_addr3", (obs2.size() >= 44) ? {24'b0, obs2[42], obs2[43]} : 32'hFFFF_FFFF, 32'hD4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_text_writer.md
# lcd_text_writer

Parametrised HD44780-style text frame writer that streams up to four display lines of ASCII text to the LCD nibble-command layer in 4-bit mode. It sits between application logic, which supplies a flat text buffer plus a per-line refresh mask, and the existing nibble transmitter, which consumes `commandToSend`/`sendCommand` and answers with `commandDone`. It generalises the two-line, 16-column sender with configurable line count and length, selective line refresh, a request snapshot and a busy flag.

## Interface
- `LINE_LENGTH`, 16: characters per line, 1..40.
- `NUM_LINES`, 2: display lines, 1..4.
- `CLK` input 1: system clock, all logic on the rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `sendText` input 1: frame request, sampled only in IDLE.
- `text` input 8*LINE_LENGTH*NUM_LINES: line 0 char 0 in the top byte, then characters in order, line by line.
- `lineMask` input NUM_LINES: bit l set means line l is written this frame.
- `busy` output 1: high from acceptance until `sendingDone`, inclusive.
- `sendingDone` output 1: one-cycle pulse when the frame is complete.
- `commandDone` input 1: nibble-transfer-complete strobe from the transmitter.
- `commandToSend` output 4: nibble to transmit.
- `sendCommand` output 1: one-cycle pulse that starts a nibble transfer.
- `read_busy` output 1: 0 on the high nibble, 1 on the low nibble. The transmitter polls BF after the low nibble.
- `commandToSendRs` output 1: RS for the current byte. 0 means instruction, 1 means data.

## Operation
- States:
  - IDLE: waits for a request.
  - LOAD: forms the next byte.
  - SEND_HI, then WAIT_HI: sends the high nibble and waits for completion.
  - SEND_LO, then WAIT_LO: sends the low nibble and waits for completion.
  - NEXT: advances the line and character pointers.
- Acceptance:
  - `sendText`=1 in IDLE snapshots `text` and `lineMask` into internal registers.
  - Later input changes do not affect the frame in progress.
  - `sendText` while `busy` is ignored; requests are not queued.
- Frame order: each line with its mask bit set, in ascending line order.
  - First, a set-DDRAM-address instruction, byte 0x80|addr with RS=0.
  - Then LINE_LENGTH data bytes with RS=1, char 0 first.
- Line addresses, all 7-bit modulo 128:
  - line 0 = 0x00
  - line 1 = 0x40
  - line 2 = LINE_LENGTH
  - line 3 = 0x40+LINE_LENGTH
- Each byte goes out as two nibbles, bits [7:4] then [3:0]. `commandToSendRs` is constant across both nibbles of a byte.
- Character counter width is $clog2(LINE_LENGTH+1). The line counter is 2 bits and never wraps past NUM_LINES-1.
- Unmasked lines are skipped with zero nibble traffic.
- `lineMask`=0: no nibbles are sent; `sendingDone` still pulses.
- `commandDone` is honoured only in WAIT_HI and WAIT_LO and ignored in every other state.
- `RESET` mid-frame aborts immediately:
  - state returns to IDLE and all outputs take their reset values;
  - no `sendingDone` pulse is produced;
  - the transmitter is reset by the same `RESET`.
- Reset values: `busy`=0, `sendingDone`=0, `sendCommand`=0, `commandToSend`=0, `read_busy`=0, `commandToSendRs`=0, state IDLE, all counters 0.

## Timing
- All outputs are registered.
- Acceptance and first nibble:
  - `sendText` high in IDLE in cycle N gives `busy`=1 from N+1.
  - LOAD occupies N+1 and SEND_HI occupies N+2.
  - `sendCommand`=1 in N+3, with the high nibble and `read_busy`=0.
- Low nibble: `commandDone` in WAIT_HI cycle M gives `sendCommand`=1 in M+2, with the low nibble and `read_busy`=1.
- After the low nibble, `commandDone` in WAIT_LO cycle K gives NEXT in K+1. Then:
  - either LOAD in K+2 and the next high-nibble pulse in K+4;
  - or, on the last byte, `sendingDone`=1 and `busy` still 1 in K+2, then `busy`=0 in K+3, when a new request can be accepted.
- `commandDone` arriving in the same cycle as the `sendCommand` pulse is accepted.
- `commandToSend`, `commandToSendRs` and `read_busy` hold stable from the pulse until the next pulse.
- Nibble count per frame = 2 × (popcount(`lineMask`) × (LINE_LENGTH+1)), plus 2 with the clear feature.

## Configuration
- `LCD_TEXT_CLEAR_EN` defined:
  - every accepted frame, including `lineMask`=0, starts with a Clear Display instruction, byte 0x01 with RS=0, sent as nibbles 0x0 then 0x1 through the normal SEND/WAIT states;
  - the line traffic follows, so total time increases by one byte transfer.
- `LCD_TEXT_CLEAR_EN` undefined: no clear instruction; unwritten lines keep their previous contents.

## Test plan
- Default params, `lineMask`=2'b11, text "HELLO WORLD     " / "0123456789ABCDEF", `commandDone` one cycle after each pulse:
  - nibble stream 8,0 (RS=0), 4,8 (RS=1), 4,5 … then C,0 (RS=0), 3,0 …;
  - 68 pulses total, one `sendingDone`, `busy` low after it.
- `lineMask`=2'b10: first byte 0xC0, 34 pulses total, line 0 untouched.
- `lineMask`=0: no `sendCommand`; `sendingDone` in N+2 after a `sendText` in cycle N.
- `NUM_LINES`=4, `LINE_LENGTH`=20, mask 4'b1100: address bytes 0x94 and 0xD4, 84 pulses total.
- Toggle `text` and `sendText` mid-frame: the output stream matches the snapshot and no second frame starts.
- `RESET` asserted during WAIT_LO: next cycle all outputs are 0 and state is IDLE, with no `sendingDone`; a fresh `sendText` restarts with byte 0x80.
